// File: rtl/preset_arbiter.sv
// Preset-button front end: per-channel sync + debounce + edge one-shot, sticky
// pending requests, lowest-index priority pick offered over valid/ready.

module preset_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_stable
);
   logic             r_sync1, r_sync2, r_stable;
   logic [CNT_W-1:0] r_cnt;

   // Any sample agreeing with the stable level restarts the count, so only an
   // uninterrupted run of DEBOUNCE_CYCLES differing samples flips the level.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt < CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end
      end
   end

   assign o_stable = r_stable;
endmodule

module preset_arbiter #(
   parameter int N_CH            = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter int ID_W            = 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [N_CH-1:0] i_presets,
   input  logic            i_clear,
   input  logic            i_req_ready,
   output logic            o_req_valid,
   output logic [ID_W-1:0] o_req_id,
   output logic [N_CH-1:0] o_req_onehot,
   output logic [N_CH-1:0] o_edge_pulse,
   output logic            o_drop_pulse
);
   typedef enum logic {S_IDLE, S_OFFER} state_t;

   logic [N_CH-1:0] w_stable, w_rise, w_accept_mask, w_low_oh, w_oh_nxt;
   logic [N_CH-1:0] r_stable_d, r_pending, r_edge, r_req_onehot;
   logic [ID_W-1:0] w_low_id, w_id_nxt, r_req_id;
   logic            w_valid_nxt, r_req_valid, r_drop;
   state_t          r_state, w_state_nxt;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      preset_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_raw   (i_presets[g]),
         .o_stable(w_stable[g])
      );
   end

   assign w_rise        = w_stable & ~r_stable_d;
   assign w_accept_mask = (r_state == S_OFFER && !i_clear && i_req_ready) ? r_req_onehot : '0;

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      w_low_id = '0;
      w_low_oh = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_low_id    = ID_W'(i);
            w_low_oh    = '0;
            w_low_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_req_id;
      w_valid_nxt = r_req_valid;
      w_oh_nxt    = r_req_onehot;
      case (r_state)
         S_IDLE: begin
            w_valid_nxt = 1'b0;
            w_oh_nxt    = '0;
            if (!i_clear && |r_pending) begin
               w_state_nxt = S_OFFER;
               w_id_nxt    = w_low_id;
               w_valid_nxt = 1'b1;
               w_oh_nxt    = w_low_oh;
            end
         end
         S_OFFER: begin
            if (i_clear || i_req_ready) begin
               w_state_nxt = S_IDLE;
               w_valid_nxt = 1'b0;
               w_oh_nxt    = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_oh_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_req_id     <= '0;
         r_req_valid  <= 1'b0;
         r_req_onehot <= '0;
         r_stable_d   <= '0;
         r_pending    <= '0;
         r_edge       <= '0;
         r_drop       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_id     <= w_id_nxt;
         r_req_valid  <= w_valid_nxt;
         r_req_onehot <= w_oh_nxt;
         r_stable_d   <= w_stable;
         r_edge       <= w_rise;
         // Clear beats a coincident edge; a same-cycle accept+edge re-arms.
         if (i_clear) begin
            r_pending <= '0;
            r_drop    <= 1'b0;
         end else begin
            r_pending <= (r_pending & ~w_accept_mask) | w_rise;
            r_drop    <= |(w_rise & r_pending & ~w_accept_mask);
         end
      end
   end

   assign o_req_valid  = r_req_valid;
   assign o_req_id     = r_req_id;
   assign o_req_onehot = r_req_onehot;
   assign o_edge_pulse = r_edge;
   assign o_drop_pulse = r_drop;
endmodule

// File: tb/tb_preset_arbiter.sv
// Directed bench for preset_arbiter: stimulus pushes expected edges/accepts into
// queues, a negedge monitor pops and compares as the DUT produces them.

module tb_preset_arbiter;
   localparam int N_CH = 3;
   localparam int ID_W = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N_CH-1:0] presets = '0;
   logic            clear = 1'b0;
   logic            req_ready = 1'b0;
   logic            req_valid;
   logic [ID_W-1:0] req_id;
   logic [N_CH-1:0] req_onehot;
   logic [N_CH-1:0] edge_pulse;
   logic            drop_pulse;

   int n_tests = 0;
   int n_fail  = 0;
   int drops_seen = 0;
   int drops_exp  = 0;
   logic [N_CH-1:0] exp_edge[$];
   logic [ID_W-1:0] exp_acc[$];

   preset_arbiter #(.N_CH(N_CH), .DEBOUNCE_CYCLES(4), .CNT_W(16), .ID_W(ID_W)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_presets   (presets),
      .i_clear     (clear),
      .i_req_ready (req_ready),
      .o_req_valid (req_valid),
      .o_req_id    (req_id),
      .o_req_onehot(req_onehot),
      .o_edge_pulse(edge_pulse),
      .o_drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_offer(input string name, input logic v, input logic [ID_W-1:0] id);
      check({name, ".valid"}, 32'(req_valid), 32'(v));
      if (v) check({name, ".id"}, 32'(req_id), 32'(id));
      check({name, ".onehot"}, 32'(req_onehot), v ? 32'(1) << id : 32'(0));
   endtask

   // Monitor: compare every edge pulse and every accepted handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (edge_pulse != '0) begin
               if (exp_edge.size() == 0) check("edge_unexpected", 32'(edge_pulse), 32'(0));
               else check("edge_pulse", 32'(edge_pulse), 32'(exp_edge.pop_front()));
            end
            if (drop_pulse) drops_seen++;
            if (req_valid && req_ready && !clear) begin
               if (exp_acc.size() == 0) check("accept_unexpected", 32'(req_id), 32'hFF);
               else begin
                  logic [ID_W-1:0] e;
                  e = exp_acc.pop_front();
                  check("accept_id", 32'(req_id), 32'(e));
                  check("accept_onehot", 32'(req_onehot), 32'(1) << e);
               end
            end
         end
      end
   end

   initial begin
      // Reset, button 0 held through release
      presets = 3'b001;
      tick(2);
      chk_offer("reset", 1'b0, '0);
      check("reset.edge", 32'(edge_pulse), 32'(0));
      check("reset.drop", 32'(drop_pulse), 32'(0));
      #2 reset = 1'b1;
      exp_edge.push_back(3'b001);
      tick(6);
      check("t1.no_edge_e6", 32'(edge_pulse), 32'(0));
      tick(1);
      check("t1.edge_e7", 32'(edge_pulse), 32'(3'b001));
      chk_offer("t1.pre_offer", 1'b0, '0);
      tick(1);
      chk_offer("t1.offer_e8", 1'b1, 2'd0);
      req_ready = 1'b1;
      exp_acc.push_back(2'd0);
      tick(1);
      req_ready = 1'b0;
      chk_offer("t1.after_accept", 1'b0, '0);
      tick(10);
      chk_offer("t1.quiet", 1'b0, '0);
      presets = 3'b000;
      tick(10);

      // Glitch: 3 sampled cycles high is rejected
      presets = 3'b010;
      tick(3);
      presets = 3'b000;
      tick(12);
      chk_offer("t2.glitch", 1'b0, '0);
      check("t2.edge", 32'(edge_pulse), 32'(0));

      // Simultaneous 1 and 2: id 1 first, held, then id 2
      presets = 3'b110;
      exp_edge.push_back(3'b110);
      tick(8);
      chk_offer("t3.offer1", 1'b1, 2'd1);
      for (int c = 0; c < 10; c++) begin
         tick(1);
         chk_offer("t3.hold1", 1'b1, 2'd1);
      end
      req_ready = 1'b1;
      exp_acc.push_back(2'd1);
      tick(1);
      req_ready = 1'b0;
      chk_offer("t3.gap", 1'b0, '0);
      tick(1);
      chk_offer("t3.offer2", 1'b1, 2'd2);

      // Merge: re-press 2 while it is still offered
      presets = 3'b000;
      tick(8);
      chk_offer("t4.still2", 1'b1, 2'd2);
      presets = 3'b100;
      exp_edge.push_back(3'b100);
      drops_exp++;
      tick(12);
      chk_offer("t4.offer2", 1'b1, 2'd2);
      check("t4.drops", 32'(drops_seen), 32'(1));
      req_ready = 1'b1;
      exp_acc.push_back(2'd2);
      tick(1);
      req_ready = 1'b0;
      chk_offer("t4.accepted", 1'b0, '0);
      tick(5);
      chk_offer("t4.empty", 1'b0, '0);
      presets = 3'b000;
      tick(10);

      // Clear beats ready during an offer; pending 011 flushed
      presets = 3'b011;
      exp_edge.push_back(3'b011);
      tick(8);
      chk_offer("t5.offer0", 1'b1, 2'd0);
      clear = 1'b1;
      req_ready = 1'b1;
      tick(1);
      clear = 1'b0;
      req_ready = 1'b0;
      chk_offer("t5.cleared", 1'b0, '0);
      tick(5);
      chk_offer("t5.flushed", 1'b0, '0);
      presets = 3'b000;
      tick(10);

      // Async reset mid-offer, button held through release
      presets = 3'b001;
      exp_edge.push_back(3'b001);
      tick(8);
      chk_offer("t6.offer0", 1'b1, 2'd0);
      #3 reset = 1'b0;
      #1;
      check("t6.rst_valid", 32'(req_valid), 32'(0));
      check("t6.rst_onehot", 32'(req_onehot), 32'(0));
      check("t6.rst_edge", 32'(edge_pulse), 32'(0));
      tick(3);
      exp_edge.push_back(3'b001);
      #2 reset = 1'b1;
      tick(6);
      check("t6.no_edge_e6", 32'(edge_pulse), 32'(0));
      tick(1);
      check("t6.edge_e7", 32'(edge_pulse), 32'(3'b001));
      tick(1);
      chk_offer("t6.offer_e8", 1'b1, 2'd0);
      req_ready = 1'b1;
      exp_acc.push_back(2'd0);
      tick(1);
      req_ready = 1'b0;
      chk_offer("t6.accepted", 1'b0, '0);
      presets = 3'b000;
      tick(10);

      check("end.edges_left", 32'(exp_edge.size()), 32'(0));
      check("end.accepts_left", 32'(exp_acc.size()), 32'(0));
      check("end.drops", 32'(drops_seen), 32'(drops_exp));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/preset_arbiter.md
Name: preset_arbiter

Overview:
- N-channel preset-button front end for the drawing robot; successor to the fixed 3-button edge detector.
- Per channel: 2-flop synchroniser, counter-based debounce, registered rising-edge one-shot.
- Sticky pending request per channel; priority arbitration; one selected preset handed to the drawing FSM over a valid/ready handshake.
- Sits between board push-buttons and the shape-sequencer FSM.

Parameters:
- N_CH, 3, number of preset buttons/channels; ID_W must satisfy N_CH <= 2^ID_W.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples needed to accept a level change; minimum 2, 50000 on board.
- CNT_W, 16, debounce counter width; DEBOUNCE_CYCLES-1 must fit in CNT_W bits.
- ID_W, 2, width of req_id.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- presets  in  N_CH  raw asynchronous button levels, bit i = channel i.
- clear  in  1  synchronous flush of all pending requests.
- req_ready  in  1  consumer accepts the offered request.
- req_valid  out  1  request offered.
- req_id  out  ID_W  index of offered channel.
- req_onehot  out  N_CH  one-hot of req_id, zero when req_valid=0.
- edge_pulse  out  N_CH  one-cycle debounced rising-edge pulse per channel.
- drop_pulse  out  1  one-cycle pulse: an edge was merged into an already-pending request.

Behaviour:
- Reset (reset=0, async): sync flops, stable levels, counters, pending, FSM state and all outputs go to 0; FSM enters IDLE.
  - Reset mid-offer abandons the request.
  - A button held through reset release produces an edge after debounce.
- Synchroniser: sync_q[i] is presets[i] delayed two flops.
- Debounce, per channel:
  - If sync_q equals stable, counter <= 0.
  - Else, if counter < DEBOUNCE_CYCLES-1, counter increments.
  - Else stable <= sync_q and counter <= 0.
  - Any return to equality before the flip resets the counter, so glitches shorter than DEBOUNCE_CYCLES samples are rejected.
  - Falling edges are debounced identically but produce no events.
- Edge latency: raw high first sampled at edge k gives:
  - stable=1 after edge k+DEBOUNCE_CYCLES+1;
  - edge_pulse[i]=1 and pending[i] set after edge k+DEBOUNCE_CYCLES+2, with edge_pulse high exactly one cycle;
  - req_valid at the earliest after edge k+DEBOUNCE_CYCLES+3.
- Pending bits: set by edge; cleared by accept of that channel or by clear.
  - Edge and accept on the same channel in the same cycle: pending stays set, counted as a new request.
  - Edge on a channel already pending and not being cleared: pending unchanged, drop_pulse=1 next cycle.
  - Edge in the same cycle as clear: the clear wins and the edge is lost; no drop_pulse.
- FSM IDLE:
  - req_valid=0.
  - If clear=0 and any pending bit is set, latch the lowest set index into req_id and go to OFFER.
- FSM OFFER:
  - req_valid=1; req_id and req_onehot held stable while waiting.
  - clear=1: go to IDLE, all pending bits cleared; clear has priority over req_ready.
  - Else req_ready=1: accept, clear pending[req_id], go to IDLE.
  - Outputs are registered, so req_valid drops the cycle after accept; minimum 2 cycles between offers.
- Priority: lowest channel index wins.
  - The offered id never changes mid-offer, even if a higher-priority edge arrives.
  - Starvation is acceptable; button rates are human-speed.
- clear while in IDLE: pending bits cleared, FSM stays IDLE.
- Debounce and edge detection run independently of FSM state and of clear.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold presets=3'b001 from before edge 1.
  -> edge_pulse[0] after edge 7; req_valid=1, req_id=0, req_onehot=001 after edge 8.
  -> req_ready=1 for one cycle -> req_valid=0 next cycle; no further requests.
- Glitch: presets[1] high for 3 sampled cycles, then low.
  -> no edge_pulse, no req_valid; counter returns to 0.
- Simultaneous: presets 3'b000 -> 3'b110 together, req_ready=0.
  -> req_id=1 offered and held for 10 cycles; after accept, the next offer is req_id=2 two cycles later.
- Merge: while channel 2 is offered and unaccepted, release and re-press button 2 (each held >= 6 cycles).
  -> one drop_pulse, a single offer of id 2, accepted once; pending empty afterwards.
- Clear: pending 3'b011, assert clear for one cycle during OFFER with req_ready=1.
  -> req_valid=0 next cycle, pending=0, no accept of id 0.
- Async reset: assert reset low mid-offer, asynchronous to clk.
  -> req_valid, req_onehot and edge_pulse go to 0 immediately.
  -> after release, a held button yields a fresh offer at the debounce latency.
